// File: rtl/fir_coeff_bank.sv
// -----------------------------------------------------------------------------
// fir_coeff_bank
//
// Double-buffered coefficient store for the FIR low-pass datapath. New taps
// are streamed serially into the shadow bank while the filter keeps reading
// the active bank. A completed set becomes active only when the filter marks
// a sample boundary (swap_ok), so the taps change atomically and never in the
// middle of a convolution.
//
// Parameters:
//   WORD_SIZE    coefficient width in bits
//   TAPS         coefficients per bank (>= 2)
//   ADDR_W       derived tap index width, $clog2(TAPS)
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   addr         tap index read from the active bank
//   out_data     registered coefficient read (1-cycle latency)
//   load_data    next coefficient to load, tap 0 first
//   load_valid   load_data is valid
//   load_ready   block accepts a load beat this cycle
//   load_restart discard the partial or pending set and restart at tap 0
//   swap_ok      filter is at a sample boundary, swap permitted
//   pending      shadow bank holds a complete set awaiting swap
//   swap_done    one-cycle pulse on the cycle after a bank swap
//   bank_sel     index of the active bank
//   coeff_valid  active bank holds a loaded set (sticky until reset)
// -----------------------------------------------------------------------------
module fir_coeff_bank #(
  parameter  int WORD_SIZE = 8,
  parameter  int TAPS      = 8,
  localparam int ADDR_W    = $clog2(TAPS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_W-1:0]    addr,
  output logic [WORD_SIZE-1:0] out_data,
  input  logic [WORD_SIZE-1:0] load_data,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic                 load_restart,
  input  logic                 swap_ok,
  output logic                 pending,
  output logic                 swap_done,
  output logic                 bank_sel,
  output logic                 coeff_valid
);

  localparam logic [0:0]        S_LOAD   = 1'b0;
  localparam logic [0:0]        S_PEND   = 1'b1;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(TAPS - 1);

  logic [WORD_SIZE-1:0] bank_q [2][TAPS];

  logic [0:0]           state_q, state_d;
  logic [ADDR_W-1:0]    ptr_q, ptr_d;
  logic                 bankSel_q, bankSel_d;
  logic                 coeffValid_q, coeffValid_d;
  logic                 swapDone_q, swapDone_d;
  logic [WORD_SIZE-1:0] outData_q, outData_d;

  logic beat;
  logic swapNow;
  logic addrInRange;

  // A restart in the same cycle suppresses both the beat and the swap, which
  // gives load_restart priority over every other event.
  assign load_ready = (state_q == S_LOAD);
  assign beat       = load_valid & load_ready & ~load_restart;
  assign swapNow    = (state_q == S_PEND) & swap_ok & ~load_restart;

  // For a non-power-of-two bank, addresses past the last tap read as zero.
  // A power-of-two bank has no such addresses, so no compare is built.
  generate
    if (TAPS == (1 << ADDR_W)) begin : gPow2
      assign addrInRange = 1'b1;
    end else begin : gNonPow2
      assign addrInRange = ({1'b0, addr} < (ADDR_W + 1)'(TAPS));
    end
  endgenerate

  // Next-state logic for the load FSM, pointer and bank selection.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    bankSel_d    = bankSel_q;
    coeffValid_d = coeffValid_q;
    swapDone_d   = swapNow;
    outData_d    = addrInRange ? bank_q[bankSel_q][addr] : '0;

    if (load_restart) begin
      ptr_d   = '0;
      state_d = S_LOAD;
    end else if (beat) begin
      if (ptr_q == LAST_PTR) begin
        ptr_d   = '0;
        state_d = S_PEND;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end else if (swapNow) begin
      state_d      = S_LOAD;
      bankSel_d    = ~bankSel_q;
      coeffValid_d = 1'b1;
    end
  end

  // Control and read-port registers. The read uses bankSel_q as it was before
  // the edge, so a read launched on the swap edge still sees the old bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_LOAD;
      ptr_q        <= '0;
      bankSel_q    <= 1'b0;
      coeffValid_q <= 1'b0;
      swapDone_q   <= 1'b0;
      outData_q    <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      bankSel_q    <= bankSel_d;
      coeffValid_q <= coeffValid_d;
      swapDone_q   <= swapDone_d;
      outData_q    <= outData_d;
    end
  end

  // Coefficient storage. Only the shadow bank (!bankSel_q) is ever written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int t = 0; t < TAPS; t++) begin
          bank_q[b][t] <= '0;
        end
      end
    end else if (beat) begin
      bank_q[~bankSel_q][ptr_q] <= load_data;
    end
  end

  assign out_data    = outData_q;
  assign pending     = (state_q == S_PEND);
  assign swap_done   = swapDone_q;
  assign bank_sel    = bankSel_q;
  assign coeff_valid = coeffValid_q;

endmodule

// File: tb/tb_fir_coeff_bank.sv
// -----------------------------------------------------------------------------
// tb_fir_coeff_bank
//
// Directed bench for fir_coeff_bank. One instance uses the default 8x8
// geometry; a second uses TAPS = 5, WORD_SIZE = 12 to cover the
// non-power-of-two read path and asynchronous reset mid-load.
// -----------------------------------------------------------------------------
module tb_fir_coeff_bank;

  logic        clk;
  logic        rst_n;
  logic [2:0]  addr;
  logic [7:0]  outData;
  logic [7:0]  loadData;
  logic        loadValid;
  logic        loadReady;
  logic        loadRestart;
  logic        swapOk;
  logic        pending;
  logic        swapDone;
  logic        bankSel;
  logic        coeffValid;

  logic        rst5N;
  logic [2:0]  addr5;
  logic [11:0] outData5;
  logic [11:0] loadData5;
  logic        loadValid5;
  logic        loadReady5;
  logic        loadRestart5;
  logic        swapOk5;
  logic        pending5;
  logic        swapDone5;
  logic        bankSel5;
  logic        coeffValid5;

  int testCount;
  int failCount;

  logic [11:0] exp5 [8];

  fir_coeff_bank #(.WORD_SIZE(8), .TAPS(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .addr         (addr),
    .out_data     (outData),
    .load_data    (loadData),
    .load_valid   (loadValid),
    .load_ready   (loadReady),
    .load_restart (loadRestart),
    .swap_ok      (swapOk),
    .pending      (pending),
    .swap_done    (swapDone),
    .bank_sel     (bankSel),
    .coeff_valid  (coeffValid)
  );

  fir_coeff_bank #(.WORD_SIZE(12), .TAPS(5)) dut5 (
    .clk          (clk),
    .rst_n        (rst5N),
    .addr         (addr5),
    .out_data     (outData5),
    .load_data    (loadData5),
    .load_valid   (loadValid5),
    .load_ready   (loadReady5),
    .load_restart (loadRestart5),
    .swap_ok      (swapOk5),
    .pending      (pending5),
    .swap_done    (swapDone5),
    .bank_sel     (bankSel5),
    .coeff_valid  (coeffValid5)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive the 8-tap instance for one cycle, then settle 1 unit past the edge.
  task automatic applyStimulus(input logic v, input logic [7:0] d,
                               input logic r, input logic s,
                               input logic [2:0] a);
    loadValid   = v;
    loadData    = d;
    loadRestart = r;
    swapOk      = s;
    addr        = a;
    @(posedge clk);
    #1;
  endtask

  // Same as applyStimulus, for the 5-tap instance.
  task automatic applyStimulus5(input logic v, input logic [11:0] d,
                                input logic r, input logic s,
                                input logic [2:0] a);
    loadValid5   = v;
    loadData5    = d;
    loadRestart5 = r;
    swapOk5      = s;
    addr5        = a;
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    testCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    testCount = 0;
    failCount = 0;
    rst_n = 1'b0;
    rst5N = 1'b0;
    loadValid = 1'b0; loadData = '0; loadRestart = 1'b0; swapOk = 1'b0; addr = '0;
    loadValid5 = 1'b0; loadData5 = '0; loadRestart5 = 1'b0; swapOk5 = 1'b0; addr5 = '0;

    // Reset values while rst_n is held low
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_data", 32'(outData), 32'h0);
    checkOutput("rst_load_ready", 32'(loadReady), 32'h1);
    checkOutput("rst_pending", 32'(pending), 32'h0);
    checkOutput("rst_swap_done", 32'(swapDone), 32'h0);
    checkOutput("rst_bank_sel", 32'(bankSel), 32'h0);
    checkOutput("rst_coeff_valid", 32'(coeffValid), 32'h0);
    rst_n = 1'b1;

    // Empty banks read as zero
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 3'(i));
      checkOutput($sformatf("empty_read_%0d", i), 32'(outData), 32'h0);
    end
    checkOutput("empty_load_ready", 32'(loadReady), 32'h1);

    // Stream 1..8 into the shadow bank
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 8'(i + 1), 1'b0, 1'b0, 3'd0);
    end
    checkOutput("set1_pending", 32'(pending), 32'h1);
    checkOutput("set1_load_ready", 32'(loadReady), 32'h0);
    checkOutput("set1_coeff_valid", 32'(coeffValid), 32'h0);
    applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0, 3'd3);
    checkOutput("set1_prewap_read3", 32'(outData), 32'h0);
    checkOutput("set1_valid_ignored", 32'(pending), 32'h1);

    // Swap and read back 1..8
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 3'd0);
    checkOutput("swap1_done", 32'(swapDone), 32'h1);
    checkOutput("swap1_bank_sel", 32'(bankSel), 32'h1);
    checkOutput("swap1_load_ready", 32'(loadReady), 32'h1);
    checkOutput("swap1_pending", 32'(pending), 32'h0);
    checkOutput("swap1_coeff_valid", 32'(coeffValid), 32'h1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 3'(i));
      if (i == 0) checkOutput("swap1_done_cleared", 32'(swapDone), 32'h0);
      checkOutput($sformatf("set1_read_%0d", i), 32'(outData), 32'(i + 1));
    end

    // Load 0x10..0x17 with swap_ok during beat 4: must be ignored
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 8'(8'h10 + i), 1'b0, (i == 3), 3'd0);
      if (i == 3) begin
        checkOutput("midload_swap_done", 32'(swapDone), 32'h0);
        checkOutput("midload_bank_sel", 32'(bankSel), 32'h1);
      end
    end
    checkOutput("set2_pending", 32'(pending), 32'h1);
    // Read launched on the swap edge returns the old bank
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 3'd2);
    checkOutput("swap2_edge_read", 32'(outData), 32'h3);
    checkOutput("swap2_done", 32'(swapDone), 32'h1);
    checkOutput("swap2_bank_sel", 32'(bankSel), 32'h0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 3'd2);
    checkOutput("swap2_next_read", 32'(outData), 32'h12);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 3'd7);
    checkOutput("swap2_read7", 32'(outData), 32'h17);

    // Partial load of 5 beats, then restart with a simultaneous beat
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 3'd0);
    end
    applyStimulus(1'b1, 8'h99, 1'b1, 1'b0, 3'd0);
    checkOutput("restart_load_ready", 32'(loadReady), 32'h1);
    checkOutput("restart_pending", 32'(pending), 32'h0);
    checkOutput("restart_bank_sel", 32'(bankSel), 32'h0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 3'd0);
    end
    checkOutput("set3_pending", 32'(pending), 32'h1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 3'd0);
    checkOutput("swap3_bank_sel", 32'(bankSel), 32'h1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 3'(i));
      checkOutput($sformatf("set3_read_%0d", i), 32'(outData), 32'(8'hA0 + i));
    end

    // swap_ok together with load_restart while pending: restart wins
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 3'd0);
    end
    checkOutput("set4_pending", 32'(pending), 32'h1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 3'd5);
    checkOutput("collide_swap_done", 32'(swapDone), 32'h0);
    checkOutput("collide_bank_sel", 32'(bankSel), 32'h1);
    checkOutput("collide_pending", 32'(pending), 32'h0);
    checkOutput("collide_load_ready", 32'(loadReady), 32'h1);
    checkOutput("collide_read5", 32'(outData), 32'hA5);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 3'd0);
    checkOutput("collide_swap_done_late", 32'(swapDone), 32'h0);
    checkOutput("collide_coeff_valid", 32'(coeffValid), 32'h1);

    // 5-tap, 12-bit instance
    rst5N = 1'b1;
    exp5[0] = 12'hFFF; exp5[1] = 12'h001; exp5[2] = 12'h002; exp5[3] = 12'h003;
    exp5[4] = 12'h004; exp5[5] = 12'h000; exp5[6] = 12'h000; exp5[7] = 12'h000;
    for (int i = 0; i < 5; i++) begin
      applyStimulus5(1'b1, exp5[i], 1'b0, 1'b0, 3'd0);
    end
    checkOutput("t5_pending", 32'(pending5), 32'h1);
    checkOutput("t5_load_ready", 32'(loadReady5), 32'h0);
    applyStimulus5(1'b0, 12'h000, 1'b0, 1'b1, 3'd0);
    checkOutput("t5_swap_done", 32'(swapDone5), 32'h1);
    checkOutput("t5_bank_sel", 32'(bankSel5), 32'h1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus5(1'b0, 12'h000, 1'b0, 1'b0, 3'(i));
      checkOutput($sformatf("t5_read_%0d", i), 32'(outData5), 32'(exp5[i]));
    end

    // Asynchronous reset mid-load: outputs return to reset immediately
    applyStimulus5(1'b1, 12'h0AB, 1'b0, 1'b0, 3'd0);
    applyStimulus5(1'b1, 12'h0CD, 1'b0, 1'b0, 3'd0);
    #2;
    rst5N = 1'b0;
    #1;
    checkOutput("t5_arst_out_data", 32'(outData5), 32'h0);
    checkOutput("t5_arst_bank_sel", 32'(bankSel5), 32'h0);
    checkOutput("t5_arst_coeff_valid", 32'(coeffValid5), 32'h0);
    checkOutput("t5_arst_load_ready", 32'(loadReady5), 32'h1);
    checkOutput("t5_arst_pending", 32'(pending5), 32'h0);
    checkOutput("t5_arst_swap_done", 32'(swapDone5), 32'h0);
    @(posedge clk);
    #1;
    rst5N = 1'b1;
    applyStimulus5(1'b0, 12'h000, 1'b0, 1'b0, 3'd0);
    checkOutput("t5_post_rst_read0", 32'(outData5), 32'h0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/fir_coeff_bank.md
# fir_coeff_bank

Double-buffered, parametrised coefficient store for the FIR low-pass datapath. Coefficients are streamed in serially over a valid/ready handshake into a shadow bank while the filter keeps reading a stable active bank. A completed set is committed by swapping banks only when the filter signals a sample boundary, so the taps change atomically and never mid-convolution. The MAC datapath reads one tap per cycle through a registered read port.

## Interface
- WORD_SIZE, 8, coefficient width in bits
- TAPS, 8, coefficients per bank (≥2); ADDR_W = $clog2(TAPS) is a derived localparam, not overridable

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- addr  in  ADDR_W  tap index read from the active bank
- out_data  out  WORD_SIZE  registered coefficient read
- load_data  in  WORD_SIZE  next coefficient to load, tap 0 first
- load_valid  in  1  load_data is valid
- load_ready  out  1  block accepts a load beat this cycle
- load_restart  in  1  discard the partial or pending set and restart at tap 0
- swap_ok  in  1  filter is at a sample boundary, so a swap is permitted
- pending  out  1  shadow bank holds a complete set awaiting swap
- swap_done  out  1  one-cycle pulse on the cycle after a bank swap
- bank_sel  out  1  index of the active bank
- coeff_valid  out  1  active bank holds a loaded set (sticky until reset)

## Operation
- Storage is two banks of TAPS × WORD_SIZE registers. The shadow bank is always !bank_sel.
- A load pointer ptr (ADDR_W bits) indexes the shadow bank. The FSM has two states: LOAD and PEND.
- LOAD state:
  - load_ready = 1.
  - A beat is the condition load_valid & load_ready. Each beat writes shadow[ptr] ← load_data and increments ptr.
  - The beat at ptr = TAPS-1 sets ptr ← 0 and moves the FSM to PEND.
- PEND state:
  - load_ready = 0 and pending = 1. load_valid is ignored.
  - When swap_ok = 1: bank_sel toggles, coeff_valid ← 1, swap_done pulses, and the FSM returns to LOAD.
- swap_ok in LOAD is ignored.
- load_restart has priority over every other event in both states. It sets ptr ← 0 and state ← LOAD. Any beat in the same cycle is dropped. A pending set is discarded and bank_sel is unchanged.
- Read path: out_data ← active[addr], sampled with bank_sel as it was before the clock edge.
  - When TAPS is not a power of two, addr ≥ TAPS returns 0.
- The active bank is never written. Bank contents are preserved across swaps; only the shadow is overwritten by loads.

## Timing
- Reset, asynchronous, all values in effect while rst_n = 0:
  - out_data = 0, both banks = 0, ptr = 0, state = LOAD.
  - bank_sel = 0, load_ready = 1, pending = 0, swap_done = 0, coeff_valid = 0.
- Read latency is 1 cycle: addr presented in cycle n gives out_data valid after edge n+1. Full throughput, one read per cycle.
- Load throughput is one beat per cycle. TAPS consecutive beats complete a set in TAPS cycles. load_ready drops on the edge that accepts the last beat.
- Swap edge: if swap_ok is sampled high in PEND at edge k:
  - bank_sel flips after edge k.
  - A read launched at edge k returns the old bank; reads issued after edge k return the new bank.
  - swap_done is high for the cycle following edge k only.
  - load_ready is high again after edge k, so the next set may start the following cycle.
- swap_ok and load_restart in the same PEND cycle: restart wins and no swap occurs.
- Reset mid-load or while pending: everything returns to reset values and the partial set is lost.

## Test plan
- Reset, then read addr 0..7 → out_data = 0 every cycle; coeff_valid = 0, bank_sel = 0, load_ready = 1.
- Stream 8 beats 1..8 back-to-back with swap_ok = 0 → pending = 1, load_ready = 0, reads still return 0. Pulse swap_ok → swap_done one cycle later, bank_sel = 1; reads of addr 0..7 return 1..8.
- While bank 1 holds 1..8, load 0x10..0x17 and assert swap_ok mid-load (at beat 4) → no swap. At the first swap_ok after the set completes → the read at the swap edge returns the old value, the next read returns the 0x1x value.
- Load 5 beats, assert load_restart together with load_valid → beat dropped, ptr = 0. A following 8-beat load 0xA0..0xA7 plus swap → reads return 0xA0..0xA7.
- In PEND, assert swap_ok and load_restart in the same cycle → no swap_done, bank_sel unchanged, pending = 0, load_ready = 1.
- TAPS = 5, WORD_SIZE = 12: load 0xFFF, 1, 2, 3, 4, then swap → reads of addr 0..4 return the loaded values, addr 5..7 return 0; assert rst_n = 0 mid-load → all outputs return to reset values immediately.
